// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_FLUSH,
    ST_FAULT
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_BUS      = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } fault_cause_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [2:0] ARPROT_INSN = 3'b100;

endpackage

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC owner issuing AXI4-Lite instruction reads and buffering one word for decode
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  output logic [XLEN-1:0] o_im_araddr,
  output logic [2:0]      o_im_arprot,
  input  logic            i_im_rvalid,
  output logic            o_im_rready,
  input  logic [XLEN-1:0] i_im_rdata,
  input  logic [1:0]      i_im_rresp,
  output logic            o_if_valid,
  input  logic            i_du_ready,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  input  logic            i_ex_redirect,
  input  logic [XLEN-1:0] i_ex_target,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause,
  output logic [XLEN-1:0] o_fault_addr
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pend_target, pend_target_n;
  logic            pend, pend_n;
  logic [XLEN-1:0] instr_q, instr_n;
  logic [XLEN-1:0] if_pc_q, if_pc_n;
  fault_cause_e    cause_q, cause_n;
  logic [XLEN-1:0] fault_addr_q, fault_addr_n;
  logic            load_req;
  logic [XLEN-1:0] load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      pend_target  <= '0;
      pend         <= 1'b0;
      instr_q      <= '0;
      if_pc_q      <= '0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pend_target  <= pend_target_n;
      pend         <= pend_n;
      instr_q      <= instr_n;
      if_pc_q      <= if_pc_n;
      cause_q      <= cause_n;
      fault_addr_q <= fault_addr_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_target_n = pend_target;
    pend_n        = pend;
    instr_n       = instr_q;
    if_pc_n       = if_pc_q;
    cause_n       = cause_q;
    fault_addr_n  = fault_addr_q;
    load_req      = 1'b0;
    load_val      = '0;

    unique case (state)
      ST_IDLE: begin
        if (i_ex_redirect) begin
          load_req = 1'b1;
          load_val = i_ex_target;
        end else begin
          state_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // The AR request must stay stable, so a redirect here only waits for the handshake.
        if (i_ex_redirect) pend_target_n = i_ex_target;
        if (i_im_arready) begin
          state_n = (i_ex_redirect || pend) ? ST_FLUSH : ST_DATA;
          pend_n  = 1'b0;
        end else if (i_ex_redirect) begin
          pend_n = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_ex_redirect) begin
          if (i_im_rvalid) begin
            load_req = 1'b1;
            load_val = i_ex_target;
          end else begin
            pend_target_n = i_ex_target;
            state_n       = ST_FLUSH;
          end
        end else if (i_im_rvalid) begin
          if (i_im_rresp == RESP_OKAY) begin
            instr_n = i_im_rdata;
            if_pc_n = pc;
            pc_n    = pc + XLEN'(4);
            state_n = ST_HOLD;
          end else begin
            cause_n      = CAUSE_BUS;
            fault_addr_n = pc;
            state_n      = ST_FAULT;
          end
        end
      end
      ST_HOLD: begin
        if (i_ex_redirect) begin
          load_req = 1'b1;
          load_val = i_ex_target;
        end else if (i_du_ready) begin
          state_n = ST_ADDR;
        end
      end
      ST_FLUSH: begin
        if (i_im_rvalid) begin
          load_req = 1'b1;
          load_val = i_ex_redirect ? i_ex_target : pend_target;
        end else if (i_ex_redirect) begin
          pend_target_n = i_ex_target;
        end
      end
      ST_FAULT: begin
      end
      default: state_n = ST_FAULT;
    endcase

    // Alignment is checked only when a target actually enters the PC.
    if (load_req) begin
      if (load_val[1:0] != 2'b00) begin
        cause_n      = CAUSE_MISALIGN;
        fault_addr_n = load_val;
        state_n      = ST_FAULT;
      end else begin
        pc_n    = load_val;
        state_n = ST_ADDR;
      end
    end
  end

  assign o_im_arvalid  = (state == ST_ADDR);
  assign o_im_araddr   = pc;
  assign o_im_arprot   = ARPROT_INSN;
  assign o_im_rready   = (state == ST_DATA) || (state == ST_FLUSH);
  assign o_if_valid    = (state == ST_HOLD);
  assign o_if_instr    = instr_q;
  assign o_if_pc       = if_pc_q;
  assign o_fault       = (state == ST_FAULT);
  assign o_fault_cause = cause_q;
  assign o_fault_addr  = fault_addr_q;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer sitting between the program counter and the decode stage. Owns the PC, issues AXI4-Lite reads on the instruction-memory AR channel, accepts the R beat, and presents one buffered instruction plus its PC to decode with a valid/ready handshake. Handles redirects from execute, including discarding an in-flight fetch, and stops on bus or alignment faults.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- o_im_arvalid  out  1  AR valid
- i_im_arready  in  1  AR ready
- o_im_araddr  out  XLEN  fetch address
- o_im_arprot  out  3  constant 3'b100 (instruction, secure, unprivileged)
- i_im_rvalid  in  1  R valid
- o_im_rready  out  1  R ready
- i_im_rdata  in  XLEN  instruction word
- i_im_rresp  in  2  response; 2'b00 = OKAY
- o_if_valid  out  1  instruction available to decode
- i_du_ready  in  1  decode accepts
- o_if_instr  out  XLEN  buffered instruction
- o_if_pc  out  XLEN  address of o_if_instr
- i_ex_redirect  in  1  one-cycle redirect pulse
- i_ex_target  in  XLEN  redirect address
- o_fault  out  1  sticky fault flag
- o_fault_cause  out  2  0 none, 1 bus error, 2 misaligned target
- o_fault_addr  out  XLEN  address that faulted

## Operation
- States: IDLE, ADDR, DATA, HOLD, FLUSH, FAULT. One outstanding read max.
- IDLE: entered only from reset; moves to ADDR on the first clock after rst deasserts.
- ADDR: o_im_arvalid=1, o_im_araddr=pc. Address and valid held stable until arready (AXI rule); on handshake go to DATA.
- DATA: o_im_rready=1. On rvalid with OKAY: capture rdata into o_if_instr, pc into o_if_pc, pc<=pc+4 (mod 2^XLEN, wraps silently), go to HOLD. Non-OKAY: go to FAULT, cause 1, fault_addr=pc.
- HOLD: o_if_valid=1. On i_du_ready go to ADDR; instr/pc registers unchanged.
- Redirect handling. Redirect beats every other event in the same cycle.
  - IDLE/HOLD: pc<=target, drop o_if_valid, go to ADDR.
  - ADDR: latch pending target. When the handshake completes (same cycle or later), go to FLUSH.
  - DATA: latch target and go to FLUSH. If rvalid arrives in that same cycle, drop the beat and go directly to ADDR with the target.
  - FLUSH: o_im_rready=1. Drop the next R beat regardless of rresp, then pc<=pending target and go to ADDR. A further redirect overwrites the pending target.
- Target with bits [1:0] != 0: go to FAULT at the point the target would be loaded into pc; cause 2, fault_addr=target.
- FAULT: all valids/readies 0, o_fault=1. Leaves only on rst.

## Timing
- Reset values: arvalid 0, rready 0, araddr RESET_PC, if_valid 0, if_instr 0, if_pc 0, fault 0, fault_cause 0, fault_addr 0, pc RESET_PC, state IDLE.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Minimum loop, zero-wait memory: ADDR(1) + DATA(1) + HOLD(≥1) = 3 cycles per instruction. o_if_valid rises the cycle after the R handshake.
- o_if_valid falls the cycle after the valid&ready handshake. arvalid rises that same cycle.
- rst asserted mid-transaction: immediate return to reset values. The in-flight beat is not tracked. Memory is reset on the same rst.

## Structure
- Package fetch_pkg: fetch_state_e enum, fault_cause_e enum, RESP_OKAY, ARPROT_INSN constants.
- Single module, one FSM plus pc, pending-target and output registers. No sub-module.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, decode always ready -> araddr 0x100, 0x104, 0x108 on successive ADDR cycles; if_valid every 3rd cycle with matching if_pc.
- Decode holds i_du_ready=0 for 5 cycles -> if_valid/if_instr/if_pc stable; no new AR until accept.
- Redirect to 0x200 while in DATA, R beat 2 cycles later -> beat dropped, if_valid stays 0, next araddr=0x200.
- Redirect in ADDR with arready low 3 cycles -> araddr unchanged until handshake, then FLUSH, then araddr=target.
- rresp=2'b10 at pc 0x104 -> FAULT, o_fault=1, cause 1, fault_addr 0x104, no further AR until rst.
- Redirect to 0x202 -> cause 2, fault_addr 0x202; rst mid-DATA restores all reset values.
